// File: rtl/shift_reg_pkg.sv
// Shared definitions for shift_reg_unit: op codes, FSM encoding and op classification.
package shift_reg_pkg;

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_SHL  = 3'd1;
   localparam logic [2:0] OP_SHR  = 3'd2;
   localparam logic [2:0] OP_ROL  = 3'd3;
   localparam logic [2:0] OP_ROR  = 3'd4;
   localparam logic [2:0] OP_ASR  = 3'd5;
   localparam logic [2:0] OP_CLR  = 3'd6;
   localparam logic [2:0] OP_NOP  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Ops that run through the multi-cycle SHIFT state.
   function automatic logic is_shift_op(input logic [2:0] op);
      logic res;
      case (op)
         OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: res = 1'b1;
         default:                                res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/shift_reg_unit_step.sv
// Single-step shift/rotate evaluator: next register value and the bit pushed out.
module shift_step
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [2:0]       op,
   input  logic             sin,
   output logic [WIDTH-1:0] q_next,
   output logic             out_bit
);

   // One-position move per op; non-shift ops hold the value.
   always_comb begin
      q_next  = q;
      out_bit = 1'b0;
      case (op)
         OP_SHL: begin
            q_next  = {q[WIDTH-2:0], sin};
            out_bit = q[WIDTH-1];
         end
         OP_SHR: begin
            q_next  = {sin, q[WIDTH-1:1]};
            out_bit = q[0];
         end
         OP_ROL: begin
            q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
            out_bit = q[WIDTH-1];
         end
         OP_ROR: begin
            q_next  = {q[0], q[WIDTH-1:1]};
            out_bit = q[0];
         end
         OP_ASR: begin
            q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
            out_bit = q[0];
         end
         default: begin
            q_next  = q;
            out_bit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shift_reg_unit.sv
// Multi-mode WIDTH-bit register: load/clear immediately, shift/rotate one bit per
// cycle under a start/busy/done handshake. All outputs come straight from flops.
module shift_reg_unit
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [CNT_W-1:0] amt,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r,   cnt_s;
   logic [2:0]       op_r,    op_s;
   logic [WIDTH-1:0] q_r,     q_s;
   logic             sout_r,  sout_s;
   logic             busy_r,  busy_s;
   logic             done_r,  done_s;
   logic [WIDTH-1:0] step_q_s;
   logic             step_out_s;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .q       (q_r),
      .op      (op_r),
      .sin     (sin),
      .q_next  (step_q_s),
      .out_bit (step_out_s)
   );

   // Next-state, next-data and next-flag logic for the accept/shift/done sequence.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      op_s    = op_r;
      q_s     = q_r;
      sout_s  = sout_r;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if (is_shift_op(op)) begin
                  if (amt == CNT_ZERO) begin
                     state_s = ST_DONE;
                     done_s  = 1'b1;
                  end else begin
                     op_s    = op;
                     cnt_s   = amt;
                     state_s = ST_SHIFT;
                     busy_s  = 1'b1;
                  end
               end else begin
                  case (op)
                     OP_LOAD: q_s = d;
                     OP_CLR:  q_s = {WIDTH{1'b0}};
                     default: q_s = q_r;
                  endcase
                  state_s = ST_DONE;
                  done_s  = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            q_s    = step_q_s;
            sout_s = step_out_s;
            cnt_s  = cnt_r - CNT_ONE;
            // cnt==0 cannot occur here; treated as the last step so SHIFT always exits.
            if (cnt_r <= CNT_ONE) begin
               cnt_s   = CNT_ZERO;
               state_s = ST_DONE;
               done_s  = 1'b1;
            end else begin
               busy_s  = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // State, counter, op latch and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         op_r    <= OP_NOP;
         q_r     <= {WIDTH{1'b0}};
         sout_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         op_r    <= op_s;
         q_r     <= q_s;
         sout_r  <= sout_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign q    = q_r;
   assign sout = sout_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_shift_reg_unit.sv
// Directed self-checking bench for shift_reg_unit (WIDTH=8) with hand-computed vectors.
module tb_shift_reg_unit;
   import shift_reg_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [2:0]       op = OP_NOP;
   logic [CNT_W-1:0] amt = 4'd0;
   logic [WIDTH-1:0] d = 8'h00;
   logic             sin = 1'b0;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic             busy;
   logic             done;

   int n_cmp = 0;
   int n_err = 0;

   shift_reg_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .amt   (amt),
      .d     (d),
      .sin   (sin),
      .q     (q),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request mid-cycle; returns 1 time unit after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [CNT_W-1:0] a, input logic [WIDTH-1:0] dv);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      amt   = a;
      d     = dv;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] rol_q [3] = '{8'h4B, 8'h96, 8'h2D};
   logic       rol_o [3] = '{1'b1, 1'b0, 1'b1};
   logic [7:0] asr_q [2] = '{8'hC8, 8'hE4};

   initial begin
      int dones;
      int steps;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_sout", 32'(sout), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(OP_LOAD, 4'd0, 8'hA5);
      chk("load_q", 32'(q), 32'hA5);
      chk("load_done", 32'(done), 32'h1);
      chk("load_busy", 32'(busy), 32'h0);
      step();
      chk("load_done_drop", 32'(done), 32'h0);

      issue(OP_ROL, 4'd3, 8'h00);
      chk("rol_busy0", 32'(busy), 32'h1);
      chk("rol_q0", 32'(q), 32'hA5);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rol_q%0d", i + 1), 32'(q), 32'(rol_q[i]));
         chk($sformatf("rol_sout%0d", i + 1), 32'(sout), 32'(rol_o[i]));
         chk($sformatf("rol_busy%0d", i + 1), 32'(busy), (i < 2) ? 32'h1 : 32'h0);
         chk($sformatf("rol_done%0d", i + 1), 32'(done), (i < 2) ? 32'h0 : 32'h1);
      end

      issue(OP_LOAD, 4'd0, 8'h90);
      issue(OP_ASR, 4'd2, 8'h00);
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("asr_q%0d", i + 1), 32'(q), 32'(asr_q[i]));
         chk($sformatf("asr_sout%0d", i + 1), 32'(sout), 32'h0);
      end
      chk("asr_done", 32'(done), 32'h1);

      // SHL with a second start presented while busy; it must be dropped.
      issue(OP_CLR, 4'd0, 8'h00);
      sin = 1'b1;
      issue(OP_SHL, 4'd4, 8'h00);
      dones = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c < 2) begin
            start = 1'b1;
            op    = OP_LOAD;
            d     = 8'hFF;
            amt   = 4'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      chk("shl_q", 32'(q), 32'h0F);
      chk("shl_sout", 32'(sout), 32'h0);
      chk("shl_done_count", 32'(dones), 32'd1);
      sin = 1'b0;

      issue(OP_LOAD, 4'd0, 8'h3C);
      issue(OP_SHR, 4'd0, 8'h00);
      chk("shr0_q", 32'(q), 32'h3C);
      chk("shr0_done", 32'(done), 32'h1);
      chk("shr0_busy", 32'(busy), 32'h0);
      issue(OP_CLR, 4'd0, 8'h00);
      chk("b2b_clr_q", 32'(q), 32'h00);
      chk("b2b_clr_done", 32'(done), 32'h1);
      step();
      chk("b2b_done_drop", 32'(done), 32'h0);

      // amt beyond WIDTH: ROR by 9 behaves as ROR by 1, still taking 9 steps.
      issue(OP_LOAD, 4'd0, 8'h01);
      issue(OP_ROR, 4'd9, 8'h00);
      steps = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         steps++;
         if (done) break;
      end
      chk("ror9_steps", 32'(steps), 32'd9);
      chk("ror9_q", 32'(q), 32'h80);
      chk("ror9_sout", 32'(sout), 32'h1);

      // Asynchronous reset between edges in the middle of a shift.
      issue(OP_LOAD, 4'd0, 8'hFF);
      issue(OP_SHL, 4'd5, 8'h00);
      step();
      step();
      chk("pre_rst_busy", 32'(busy), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_q", 32'(q), 32'h00);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_done", 32'(done), 32'h0);
      chk("mid_rst_sout", 32'(sout), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(OP_LOAD, 4'd0, 8'h5A);
      chk("post_rst_q", 32'(q), 32'h5A);
      chk("post_rst_done", 32'(done), 32'h1);
      chk("post_rst_busy", 32'(busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
